// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: bus addresses, CTRL
// field positions and the active-low hex font.
package seg7_scan_driver_pkg;

   localparam logic [31:0] SEG7_ADDR_VALUE = 32'h4000_0014;
   localparam logic [31:0] SEG7_ADDR_CTRL  = 32'h4000_0018;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_LZB_BIT = 1;
   localparam int CTRL_DP_LSB  = 4;

   localparam logic [7:0] CTRL_RESET = 8'h01;

   // Active-low {dp,g,f,e,d,c,b,a}, dp off; element [n] is the glyph for nibble n.
   localparam logic [15:0][7:0] HEX_FONT = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decode with decimal point and blanking.
// Blanking only darkens segments a..g; the decimal point is independent.
module seg7_hex_decode
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   assign seg_o = {~dp_i, blank_i ? 7'h7F : HEX_FONT[nibble_i][6:0]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Memory-mapped 4-digit seven-segment scan driver. The CPU writes VALUE/CTRL;
// the block multiplexes the digits and swaps in new values only at frame ends.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter logic [31:0] ADDR_VALUE = SEG7_ADDR_VALUE,
   parameter logic [31:0] ADDR_CTRL  = SEG7_ADDR_CTRL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        hit,
   output logic [11:0] digi
);

   // TICKS must be at least 2 for the divider to be meaningful.
   localparam int unsigned TICKS = CLK_HZ / SCAN_HZ;
   localparam int          DIV_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [15:0]      active_q, active_d;
   logic [7:0]       ctrl_q, ctrl_d;
   logic [11:0]      digi_q, digi_d;

   logic        sel_value, sel_ctrl;
   logic        wr_value, wr_ctrl;
   logic        tick, frame_end;
   logic [3:0]  upper_zero;
   logic [3:0]  dp_bits;
   logic [3:0]  cur_nibble;
   logic        cur_blank;
   logic [7:0]  cur_seg;
   logic        unused_wdata;

   assign unused_wdata = ^Write_data[31:16];

   assign sel_value = (Address == ADDR_VALUE);
   assign sel_ctrl  = (Address == ADDR_CTRL);
   assign hit       = sel_value | sel_ctrl;
   assign wr_value  = MemWrite & sel_value;
   assign wr_ctrl   = MemWrite & sel_ctrl;

   assign tick      = (div_q == DIV_LAST);
   assign frame_end = tick & (idx_q == 2'd3);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      Read_data = '0;
      if (MemRead && sel_value) begin
         Read_data = {16'h0000, shadow_q};
      end else if (MemRead && sel_ctrl) begin
         Read_data = {24'h00_0000, ctrl_q};
      end
   end

   // upper_zero[i]: nibble i and every higher nibble are zero; digit 0 is never blanked.
   assign upper_zero[3] = (active_q[15:12] == 4'h0);
   assign upper_zero[2] = upper_zero[3] & (active_q[11:8] == 4'h0);
   assign upper_zero[1] = upper_zero[2] & (active_q[7:4] == 4'h0);
   assign upper_zero[0] = 1'b0;

   assign dp_bits    = ctrl_q[CTRL_DP_LSB +: 4];
   assign cur_nibble = active_q[{idx_q, 2'b00} +: 4];
   assign cur_blank  = ctrl_q[CTRL_LZB_BIT] & upper_zero[idx_q];

   seg7_hex_decode u_decode (
      .nibble_i (cur_nibble),
      .dp_i     (dp_bits[idx_q]),
      .blank_i  (cur_blank),
      .seg_o    (cur_seg)
   );

   always_comb begin
      div_d    = tick ? '0 : div_q + 1'b1;
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      shadow_d = wr_value ? Write_data[15:0] : shadow_q;
      ctrl_d   = wr_ctrl ? Write_data[7:0] : ctrl_q;
      // Taking shadow_d makes a VALUE write on the wrap tick go straight to the display.
      active_d = frame_end ? shadow_d : active_q;
      digi_d   = 12'hFFF;
      if (ctrl_q[CTRL_EN_BIT]) begin
         digi_d = {an_onehot_low(idx_q), cur_seg};
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         idx_q    <= 2'd0;
         shadow_q <= 16'h0000;
         active_q <= 16'h0000;
         ctrl_q   <= CTRL_RESET;
         digi_q   <= 12'hFFF;
      end else begin
         div_q    <= div_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         ctrl_q   <= ctrl_d;
         digi_q   <= digi_d;
      end
   end

   assign digi = digi_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with TICKS=4 (frame = 16 cycles).
// A bench-side edge counter since reset release schedules every sample.
module tb_seg7_scan_driver;

   localparam logic [31:0] A_VALUE = 32'h4000_0014;
   localparam logic [31:0] A_CTRL  = 32'h4000_0018;
   localparam logic [31:0] A_OTHER = 32'h4000_0010;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] Address = '0;
   logic [31:0] Write_data = '0;
   logic [31:0] Read_data;
   logic        hit;
   logic [11:0] digi;

   int edges = 0;
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [15:0]      value;
      logic [7:0]       ctrl;
      logic [3:0][11:0] exp;
   } vec_t;

   vec_t vecs[8];

   seg7_scan_driver #(
      .CLK_HZ  (8),
      .SCAN_HZ (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .hit        (hit),
      .digi       (digi)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) edges <= 0;
      else       edges <= edges + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic wait_edges(input int target);
      int guard = 0;
      while (edges < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (edges != target) begin
         n_total++;
         $display("FAIL sync: at edge %0d, wanted edge %0d", edges, target);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      Address    = addr;
      Write_data = data;
      MemWrite   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      MemWrite   = 1'b0;
      Address    = '0;
      Write_data = '0;
   endtask

   task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      Address = addr;
      MemRead = 1'b1;
      #1;
      check(name, Read_data, exp);
      MemRead = 1'b0;
      Address = '0;
      #1;
   endtask

   initial begin
      int frame;
      int w;
      int exp_idx;
      logic [3:0]  an_exp;
      logic [11:0] coll_exp[4];

      // {value, ctrl, {digit3, digit2, digit1, digit0}}
      vecs[0] = '{16'hC000, 8'h01, {12'h7C6, 12'hBC0, 12'hDC0, 12'hEC0}};
      vecs[1] = '{16'h0005, 8'h03, {12'h7FF, 12'hBFF, 12'hDFF, 12'hE92}};
      vecs[2] = '{16'h0000, 8'h03, {12'h7FF, 12'hBFF, 12'hDFF, 12'hEC0}};
      vecs[3] = '{16'h0008, 8'h21, {12'h7C0, 12'hBC0, 12'hD40, 12'hE80}};
      vecs[4] = '{16'h0300, 8'h03, {12'h7FF, 12'hBB0, 12'hDC0, 12'hEC0}};
      vecs[5] = '{16'h0000, 8'hF3, {12'h77F, 12'hB7F, 12'hD7F, 12'hE40}};
      vecs[6] = '{16'h9E7B, 8'h11, {12'h790, 12'hB86, 12'hDF8, 12'hE03}};
      vecs[7] = '{16'h4D60, 8'h03, {12'h799, 12'hBA1, 12'hD82, 12'hEC0}};
      coll_exp = '{12'hEA1, 12'hDC6, 12'hB83, 12'h788};

      // Reset state, then the first frame of zeros.
      repeat (3) @(negedge clk);
      check("rst_digi", {20'h0, digi}, 32'hFFF);
      read_chk("rst_rd_value", A_VALUE, 32'h0);
      read_chk("rst_rd_ctrl", A_CTRL, 32'h01);
      @(negedge clk);
      reset = 1'b0;
      wait_edges(1);  check("first_digi", {20'h0, digi}, 32'hEC0);
      wait_edges(2);  check("an_d0", {28'h0, digi[11:8]}, 32'hE);
      wait_edges(4);  check("an_d0_last", {28'h0, digi[11:8]}, 32'hE);
      wait_edges(5);  check("an_d1_first", {28'h0, digi[11:8]}, 32'hD);
      wait_edges(10); check("an_d2", {28'h0, digi[11:8]}, 32'hB);
      wait_edges(14); check("an_d3", {28'h0, digi[11:8]}, 32'h7);

      // Mid-frame VALUE write: frame 1 keeps showing zeros, frame 2 shows 12AF.
      wait_edges(21);
      bus_write(A_VALUE, 32'h0000_12AF);
      read_chk("tear_rd_value", A_VALUE, 32'h0000_12AF);
      wait_edges(26); check("tear_old_d2", {20'h0, digi}, 32'hBC0);
      wait_edges(30); check("tear_old_d3", {20'h0, digi}, 32'h7C0);
      wait_edges(34); check("tear_new_d0", {20'h0, digi}, 32'hE8E);
      wait_edges(38); check("tear_new_d1", {20'h0, digi}, 32'hD88);
      wait_edges(42); check("tear_new_d2", {20'h0, digi}, 32'hBA4);
      wait_edges(46); check("tear_new_d3", {20'h0, digi}, 32'h7F9);

      // Table of value/ctrl pairs, each checked over the frame after the write.
      foreach (vecs[k]) begin
         bus_write(A_CTRL, {24'h0, vecs[k].ctrl});
         bus_write(A_VALUE, {16'h0, vecs[k].value});
         frame = ((edges + 15) / 16) * 16;
         read_chk($sformatf("vec%0d_rd_value", k), A_VALUE, {16'h0, vecs[k].value});
         read_chk($sformatf("vec%0d_rd_ctrl", k), A_CTRL, {24'h0, vecs[k].ctrl});
         for (int i = 0; i < 4; i++) begin
            wait_edges(frame + 2 + 4 * i);
            check($sformatf("vec%0d_digit%0d", k, i), {20'h0, digi}, {20'h0, vecs[k].exp[i]});
         end
      end

      // Disable blanks on the next cycle; the scan keeps running underneath.
      bus_write(A_CTRL, 32'h0);
      w = edges;
      read_chk("dis_rd_ctrl", A_CTRL, 32'h0);
      wait_edges(w + 1); check("dis_digi_next", {20'h0, digi}, 32'hFFF);
      wait_edges(w + 7); check("dis_digi_later", {20'h0, digi}, 32'hFFF);
      bus_write(A_CTRL, 32'h01);
      w = edges;
      wait_edges(w + 1);
      exp_idx = (w / 4) % 4;
      an_exp  = 4'hF ^ (4'b0001 << exp_idx);
      check("dis_an_resume", {28'h0, digi[11:8]}, {28'h0, an_exp});
      wait_edges(w + 3);
      exp_idx = ((w + 2) / 4) % 4;
      an_exp  = 4'hF ^ (4'b0001 << exp_idx);
      check("dis_an_resume2", {28'h0, digi[11:8]}, {28'h0, an_exp});

      // VALUE write landing exactly on the 3->0 wrap edge is shown in that frame.
      frame = ((edges / 16) + 1) * 16;
      wait_edges(frame - 1);
      bus_write(A_VALUE, 32'h0000_ABCD);
      for (int i = 0; i < 4; i++) begin
         wait_edges(frame + 2 + 4 * i);
         check($sformatf("coll_digit%0d", i), {20'h0, digi}, {20'h0, coll_exp[i]});
      end

      // Unmatched addresses: no hit, no state change, readback zero.
      Address = A_OTHER; #1; check("hit_other", {31'h0, hit}, 32'h0);
      Address = A_VALUE; #1; check("hit_value", {31'h0, hit}, 32'h1);
      Address = A_CTRL;  #1; check("hit_ctrl", {31'h0, hit}, 32'h1);
      Address = '0;
      @(negedge clk);
      bus_write(A_OTHER, 32'h0000_5A5A);
      bus_write(32'hC000_0014, 32'h0000_1234);
      bus_write(32'h4000_0019, 32'h0000_00F0);
      read_chk("unm_rd_value", A_VALUE, 32'h0000_ABCD);
      read_chk("unm_rd_ctrl", A_CTRL, 32'h01);
      read_chk("unm_rd_other", A_OTHER, 32'h0);
      Address = A_VALUE; #1;
      check("rd_gated", Read_data, 32'h0);
      Address = '0;
      frame = ((edges / 16) + 1) * 16;
      wait_edges(frame + 2); check("unm_digit0", {20'h0, digi}, 32'hEA1);

      // Reset while digit 2 is on screen with a nonzero value and nondefault ctrl.
      bus_write(A_CTRL, 32'h33);
      frame = ((edges / 16) + 1) * 16;
      wait_edges(frame + 9);
      check("midrst_pre", {20'h0, digi}, 32'hB83);
      reset = 1'b1;
      #1;
      check("midrst_digi", {20'h0, digi}, 32'hFFF);
      read_chk("midrst_rd_value", A_VALUE, 32'h0);
      read_chk("midrst_rd_ctrl", A_CTRL, 32'h01);
      repeat (2) @(negedge clk);
      check("midrst_hold", {20'h0, digi}, 32'hFFF);
      reset = 1'b0;
      wait_edges(2); check("midrst_after_d0", {20'h0, digi}, 32'hEC0);
      wait_edges(4); check("midrst_an_e4", {28'h0, digi[11:8]}, 32'hE);
      wait_edges(5); check("midrst_an_e5", {28'h0, digi[11:8]}, 32'hD);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
